reg_dump: RTL and testbench

- Sequential read-side companion to the 32x32 CPU register file.
- On request, walks a register range through one spare combinational read port and streams (index, value) records out over a valid/ready handshake.
- Optional diff mode emits only registers whose value changed since the previous dump.
- Replaces simulation-only file dumps with a synthesizable debug/trace path; the sink is a UART/trace formatter.

---
 rtl/reg_dump.sv | 145 ++++++++++++++
 tb/tb_reg_dump.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Streams (index, value) records of a register-file range over valid/ready,
// reading one register per cycle through a spare read port; optional diff mode.
module reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        diff,
  input  logic        abort,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  // Handshake: a record transfers at a posedge where dump_valid & dump_ready;
  // dump_idx/dump_data are held from the rise of dump_valid until that edge,
  // and nothing on the record side depends combinationally on dump_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t      state_q, state_d;
  logic [4:0]  ra_q, ra_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        diff_q, diff_d;
  logic [31:0] shadow_q [32];
  logic [31:0] shadow_d [32];

  logic emit;
  logic handshake;

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    shadow_d  = shadow_q;
    emit      = !diff_q || (rd != shadow_q[ra_q]);
    handshake = valid_q && dump_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          ra_d    = FIRST_IDX;
          diff_d  = diff;
        end
      end
      S_READ: begin
        // An aborted read leaves its shadow entry untouched.
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          shadow_d[ra_q] = rd;
          idx_d          = ra_q;
          data_d         = rd;
          if (emit) begin
            valid_d = 1'b1;
            state_d = S_EMIT;
          end else if (ra_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            ra_d = ra_q + 5'd1;
          end
        end
      end
      S_EMIT: begin
        // Abort wins over a same-cycle handshake: the record is not transferred.
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (handshake) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            ra_d    = ra_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ra_q     <= 5'd0;
      valid_q  <= 1'b0;
      idx_q    <= 5'd0;
      data_q   <= 32'd0;
      done_q   <= 1'b0;
      diff_q   <= 1'b0;
      shadow_q <= '{default: 32'd0};
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      shadow_q <= shadow_d;
    end
  end

  assign ra         = ra_q;
  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign done       = done_q;
  assign busy       = (state_q == S_READ) || (state_q == S_EMIT);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: a register-file model drives rd, a negedge monitor
// collects transferred records, and a shadow model predicts diff-mode output.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        diff = 1'b0;
  logic        abort = 1'b0;
  logic        dump_ready = 1'b0;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  logic        start2 = 1'b0;
  logic        diff2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [4:0]  ra2;
  logic [31:0] rd2;
  logic        dump_valid2;
  logic [4:0]  dump_idx2;
  logic [31:0] dump_data2;
  logic        busy2;
  logic        done2;
  logic [1:0]  state_dbg2;

  logic [31:0] regs [32];
  logic [31:0] m_shadow [32];
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];
  logic [36:0] got2_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  assign rd  = (ra == 5'd0) ? 32'd0 : regs[ra];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

  reg_dump dut (
    .clk(clk), .rst(rst), .start(start), .diff(diff), .abort(abort),
    .ra(ra), .rd(rd), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  reg_dump #(.FIRST_REG(8), .LAST_REG(11)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .diff(diff2), .abort(abort2),
    .ra(ra2), .rd(rd2), .dump_valid(dump_valid2), .dump_ready(dump_ready),
    .dump_idx(dump_idx2), .dump_data(dump_data2), .busy(busy2), .done(done2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: a record counts when valid & ready at the coming edge, unless abort/rst override
  always @(negedge clk) begin
    if (dump_valid && dump_ready && !abort && !rst) got_q.push_back({dump_idx, dump_data});
    if (dump_valid2 && dump_ready && !abort2 && !rst) got2_q.push_back({dump_idx2, dump_data2});
    if (done) done_cnt++;
    if (done2) done2_cnt++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_recs(input string nm);
    int n;
    check({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rec%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // scoreboard model: what a dump of first..last should emit given the shadow
  task automatic compute_exp(input int first, input int last, input logic d);
    logic [31:0] v;
    exp_q.delete();
    for (int i = first; i <= last; i++) begin
      v = (i == 0) ? 32'd0 : regs[i];
      if (!d || v != m_shadow[i]) exp_q.push_back({5'(i), v});
      m_shadow[i] = v;
    end
  endtask

  task automatic write_reg(input int i, input logic [31:0] v);
    @(negedge clk);
    regs[i] = v;
  endtask

  task automatic start_dump(input logic d);
    got_q.delete();
    dump_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    diff  = d;
  endtask

  // cycles counted from the cycle start is high through the done cycle
  task automatic run_dump(input logic d, output int cyc);
    bit seen;
    start_dump(d);
    cyc  = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    start = 1'b0;
    check("dump_timeout", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_emit_idx(input logic [4:0] idx, input string nm);
    bit found;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (dump_valid && dump_idx == idx) begin
        found = 1;
        break;
      end
    end
    check(nm, 64'(found), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check(nm, 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        diff;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    int          exp_recs;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int cyc;
    int d0;

    vecs[0] = '{"full",      1'b0, 1'b0, 5'd0, 32'd0,          32, 66};
    vecs[1] = '{"diff_one",  1'b1, 1'b1, 5'd5, 32'h0000_0005,  1,  35};
    vecs[2] = '{"diff_none", 1'b1, 1'b0, 5'd0, 32'd0,          0,  34};

    for (int i = 0; i < 32; i++) begin
      regs[i]     = 32'd0;
      m_shadow[i] = 32'd0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ra", 64'(ra), 64'd0);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_idx", 64'(dump_idx), 64'd0);
    check("rst_data", 64'(dump_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    write_reg(1, 32'h1111_1111);
    write_reg(31, 32'hDEAD_BEEF);

    for (int v = 0; v < 3; v++) begin
      if (vecs[v].wr_en) write_reg(int'(vecs[v].wr_idx), vecs[v].wr_data);
      compute_exp(0, 31, vecs[v].diff);
      d0 = done_cnt;
      run_dump(vecs[v].diff, cyc);
      check_recs(vecs[v].name);
      check({vecs[v].name, "_nrec"}, 64'(got_q.size()), 64'(vecs[v].exp_recs));
      check({vecs[v].name, "_cycles"}, 64'(cyc), 64'(vecs[v].exp_cyc));
      check({vecs[v].name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
      if (v == 0 && got_q.size() == 32) begin
        check("full_rec1", 64'(got_q[1]), 64'({5'd1, 32'h1111_1111}));
        check("full_rec31", 64'(got_q[31]), 64'({5'd31, 32'hDEAD_BEEF}));
      end
      if (v == 1 && got_q.size() == 1)
        check("diff_one_rec", 64'(got_q[0]), 64'({5'd5, 32'h0000_0005}));
    end

    // backpressure on record 3
    write_reg(3, 32'h3333_3333);
    compute_exp(0, 31, 1'b0);
    d0 = done_cnt;
    start_dump(1'b0);
    wait_emit_idx(5'd3, "bp_reach");
    dump_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", k), 64'(dump_valid), 64'd1);
      check($sformatf("bp_idx%0d", k), 64'(dump_idx), 64'd3);
      check($sformatf("bp_data%0d", k), 64'(dump_data), 64'h3333_3333);
    end
    @(posedge clk);
    #1;
    dump_ready = 1'b1;
    wait_done("bp_done");
    check_recs("bp");
    check("bp_done_once", 64'(done_cnt - d0), 64'd1);

    // abort in EMIT at idx 10 with ready high in the same cycle
    d0 = done_cnt;
    start_dump(1'b0);
    wait_emit_idx(5'd10, "ab_reach");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_valid", 64'(dump_valid), 64'd0);
    check("ab_state", 64'(state_dbg), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("ab_no_done", 64'(done_cnt - d0), 64'd0);
    check("ab_count", 64'(got_q.size()), 64'd10);
    for (int i = 0; i <= 10; i++) m_shadow[i] = (i == 0) ? 32'd0 : regs[i];

    compute_exp(0, 31, 1'b0);
    run_dump(1'b0, cyc);
    check_recs("restart");

    // synchronous reset mid-dump at idx 20
    d0 = done_cnt;
    start_dump(1'b0);
    wait_emit_idx(5'd20, "rs_reach");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rs_ra", 64'(ra), 64'd0);
    check("rs_valid", 64'(dump_valid), 64'd0);
    check("rs_idx", 64'(dump_idx), 64'd0);
    check("rs_data", 64'(dump_data), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_state", 64'(state_dbg), 64'd0);
    repeat (3) @(negedge clk);
    check("rs_done", 64'(done_cnt - d0), 64'd0);
    for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
    compute_exp(0, 31, 1'b1);
    run_dump(1'b1, cyc);
    check_recs("post_rst");
    check("post_rst_nrec", 64'(got_q.size()), 64'd4);

    // narrow range instance, extra start while busy
    write_reg(9, 32'h9999_9999);
    got2_q.delete();
    d0 = done2_cnt;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("nr_busy", 64'(busy2), 64'd1);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (30) @(negedge clk);
    check("nr_done_once", 64'(done2_cnt - d0), 64'd1);
    check("nr_idle", 64'(busy2), 64'd0);
    exp_q.delete();
    for (int i = 8; i <= 11; i++) exp_q.push_back({5'(i), regs[i]});
    got_q = got2_q;
    check_recs("narrow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
